// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter: round-robin, packet-locked merge of commit streams into a registered 2-entry skid output with retire counters
module vx_commit_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_LANES = 4,
  parameter int NW_BITS = 2,
  parameter int DATAW = 32,
  localparam int SRCW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_INPUTS-1:0]               in_valid,
  output logic [NUM_INPUTS-1:0]               in_ready,
  input  logic [NUM_INPUTS*NW_BITS-1:0]       in_wid,
  input  logic [NUM_INPUTS*NUM_LANES-1:0]     in_tmask,
  input  logic [NUM_INPUTS*32-1:0]            in_pc,
  input  logic [NUM_INPUTS-1:0]               in_wb,
  input  logic [NUM_INPUTS*5-1:0]             in_rd,
  input  logic [NUM_INPUTS*NUM_LANES*DATAW-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]               in_sop,
  input  logic [NUM_INPUTS-1:0]               in_eop,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NW_BITS-1:0]                  out_wid,
  output logic [NUM_LANES-1:0]                out_tmask,
  output logic [31:0]                         out_pc,
  output logic                                out_wb,
  output logic [4:0]                          out_rd,
  output logic [NUM_LANES*DATAW-1:0]          out_data,
  output logic                                out_sop,
  output logic                                out_eop,
  output logic [SRCW-1:0]                     out_src,
  output logic [63:0]                         retired_instrs,
  output logic [63:0]                         retired_threads
);
  typedef struct packed {
    logic [SRCW-1:0]            src;
    logic [NW_BITS-1:0]         wid;
    logic [NUM_LANES-1:0]       tmask;
    logic [31:0]                pc;
    logic                       wb;
    logic [4:0]                 rd;
    logic [NUM_LANES*DATAW-1:0] data;
    logic                       sop;
    logic                       eop;
  } ent_t;
  ent_t head, tail, in_ent;
  logic [1:0] count;
  logic [SRCW-1:0] rr_ptr, lock_src, sel, idx;
  logic lock, found, enq, deq;
  // While locked the grant is pinned to lock_src, whether or not it is valid.
  always_comb begin
    sel = lock_src;
    found = lock;
    idx = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = SRCW'((int'(rr_ptr) + k) % NUM_INPUTS);
      if (!found && in_valid[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
    in_ready = '0;
    in_ready[sel] = !reset && found && count != 2'd2;
  end
  assign enq = in_valid[sel] && in_ready[sel];
  assign deq = out_valid && out_ready;
  assign in_ent = '{src: sel,
                    wid: in_wid[int'(sel)*NW_BITS +: NW_BITS],
                    tmask: in_tmask[int'(sel)*NUM_LANES +: NUM_LANES],
                    pc: in_pc[int'(sel)*32 +: 32],
                    wb: in_wb[sel],
                    rd: in_rd[int'(sel)*5 +: 5],
                    data: in_data[int'(sel)*NUM_LANES*DATAW +: NUM_LANES*DATAW],
                    sop: in_sop[sel],
                    eop: in_eop[sel]};
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_src <= '0;
      retired_instrs <= '0;
      retired_threads <= '0;
    end else begin
      count <= count + 2'(enq) - 2'(deq);
      if (enq) begin
        lock <= !in_ent.eop;
        lock_src <= sel;
        if (in_ent.eop) rr_ptr <= (sel == SRCW'(NUM_INPUTS - 1)) ? '0 : sel + 1'b1;
      end
      if (deq && head.eop) begin
        retired_instrs <= retired_instrs + 64'd1;
        retired_threads <= retired_threads + 64'($countones(head.tmask));
      end
    end
  end
  // head is the registered output entry; tail is the skid slot behind it.
  always_ff @(posedge clk) begin
    if (deq && count == 2'd2) head <= tail;
    else if (enq && (count == 2'd0 || (deq && count == 2'd1))) head <= in_ent;
    if (enq && !deq && count == 2'd1) tail <= in_ent;
  end
  assign out_valid = count != 2'd0;
  assign out_src = head.src;
  assign out_wid = head.wid;
  assign out_tmask = head.tmask;
  assign out_pc = head.pc;
  assign out_wb = head.wb;
  assign out_rd = head.rd;
  assign out_data = head.data;
  assign out_sop = head.sop;
  assign out_eop = head.eop;
endmodule

// File: tb/tb_vx_commit_arbiter.sv
// tb_vx_commit_arbiter: scenario tasks drive the arbiter and push expected packets; a monitor pops and compares outputs
module tb_vx_commit_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] in_valid, in_ready, in_wb, in_sop, in_eop;
  logic [7:0] in_wid;
  logic [15:0] in_tmask;
  logic [127:0] in_pc;
  logic [19:0] in_rd;
  logic [511:0] in_data;
  logic out_valid, out_ready, out_wb, out_sop, out_eop;
  logic [1:0] out_wid, out_src;
  logic [3:0] out_tmask;
  logic [31:0] out_pc;
  logic [4:0] out_rd;
  logic [127:0] out_data;
  logic [63:0] retired_instrs, retired_threads;

  vx_commit_arbiter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_pc(in_pc), .in_wb(in_wb), .in_rd(in_rd), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .out_valid(out_valid), .out_ready(out_ready),
    .out_wid(out_wid), .out_tmask(out_tmask), .out_pc(out_pc), .out_wb(out_wb), .out_rd(out_rd),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_src(out_src),
    .retired_instrs(retired_instrs), .retired_threads(retired_threads));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] wid;
    logic [3:0] tm;
    logic [31:0] pc;
    logic wb;
    logic [4:0] rd;
    logic [127:0] data;
    logic sop;
    logic eop;
  } exp_t;

  logic v [4];
  logic [31:0] pc [4];
  logic [3:0] tm [4];
  logic sp [4];
  logic ep [4];
  logic bump [4];
  exp_t sb [$];
  logic [63:0] m_instrs = '0;
  logic [63:0] m_threads = '0;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [127:0] data_of(logic [31:0] p);
    return {p ^ 32'hC0DE0003, p ^ 32'h00A50002, ~p, p};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign in_valid[g] = v[g];
    assign in_wid[g*2 +: 2] = pc[g][3:2];
    assign in_tmask[g*4 +: 4] = tm[g];
    assign in_pc[g*32 +: 32] = pc[g];
    assign in_wb[g] = pc[g][2];
    assign in_rd[g*5 +: 5] = pc[g][8:4];
    assign in_data[g*128 +: 128] = data_of(pc[g]);
    assign in_sop[g] = sp[g];
    assign in_eop[g] = ep[g];
  end

  function automatic exp_t mk(int s);
    exp_t e;
    e.src = 2'(s);
    e.wid = pc[s][3:2];
    e.tm = tm[s];
    e.pc = pc[s];
    e.wb = pc[s][2];
    e.rd = pc[s][8:4];
    e.data = data_of(pc[s]);
    e.sop = sp[s];
    e.eop = ep[s];
    return e;
  endfunction

  task automatic take(int s);
    sb.push_back(mk(s));
    bump[s] = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    for (int s = 0; s < 4; s++) if (bump[s]) begin
      pc[s] = pc[s] + 32'h44;
      bump[s] = 1'b0;
    end
  endtask

  task automatic idle_all();
    for (int s = 0; s < 4; s++) v[s] = 1'b0;
  endtask

  // Scoreboard: pop on every accepted output beat, sampled just before the edge.
  always begin
    exp_t e, got;
    @(negedge clk);
    #3;
    if (!reset && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_empty: got pc=%h src=%0d, no packet expected", out_pc, out_src);
      end else begin
        e = sb.pop_front();
        got = {out_src, out_wid, out_tmask, out_pc, out_wb, out_rd, out_data, out_sop, out_eop};
        if (got !== e) begin
          miscompares++;
          $display("FAIL pkt: got src=%0d pc=%h tm=%b sop=%b eop=%b, exp src=%0d pc=%h tm=%b sop=%b eop=%b",
                   out_src, out_pc, out_tmask, out_sop, out_eop, e.src, e.pc, e.tm, e.sop, e.eop);
        end
        if (e.eop) begin
          m_instrs = m_instrs + 64'd1;
          m_threads = m_threads + 64'($countones(e.tm));
        end
      end
    end
  end

  task automatic test_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      v[s] = 1'b1; sp[s] = 1'b1; ep[s] = 1'b1; tm[s] = 4'hF;
    end
    tick();
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_io: out_valid=%b in_ready=%b, exp 0/0000", out_valid, in_ready);
    end
    vectors++;
    if (retired_instrs !== 64'd0 || retired_threads !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: instrs=%0d threads=%0d, exp 0/0", retired_instrs, retired_threads);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] er;
    for (int k = 0; k < 5; k++) begin
      tick();
      reset = 1'b0;
      for (int s = 0; s < 4; s++) tm[s] = 4'(s + k + 1);
      #1;
      er = 4'b0001 << (k % 4);
      vectors++;
      if (in_ready !== er) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: in_ready=%b, exp %b", k, in_ready, er);
      end
      if (k < 2) begin
        vectors++;
        if (out_valid !== (k == 1)) begin
          miscompares++;
          $display("FAIL rr_latency[%0d]: out_valid=%b, exp %b", k, out_valid, k == 1);
        end
      end
      take(k % 4);
    end
    tick();
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_packet_lock();
    logic [6:0] v1t = 7'b0011001;
    logic [6:0] sp1t = 7'b0000001;
    logic [6:0] ep1t = 7'b0010000;
    logic [6:0] v2t = 7'b0111111;
    logic [3:0] er [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0000};
    for (int c = 0; c < 7; c++) begin
      tick();
      v[1] = v1t[c]; sp[1] = sp1t[c]; ep[1] = ep1t[c]; tm[1] = 4'(c + 3);
      v[2] = v2t[c]; sp[2] = 1'b1; ep[2] = 1'b1; tm[2] = 4'b1010;
      #1;
      vectors++;
      if (in_ready !== er[c]) begin
        miscompares++;
        $display("FAIL lock[%0d]: in_ready=%b, exp %b", c, in_ready, er[c]);
      end
      for (int s = 0; s < 4; s++) if (er[c][s] && v[s]) take(s);
    end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] er [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic [31:0] snap;
    snap = '0;
    idle_all();
    for (int c = 0; c < 7; c++) begin
      tick();
      v[0] = 1'b1; sp[0] = 1'b1; ep[0] = 1'b1; tm[0] = 4'b0111;
      out_ready = (c >= 5);
      #1;
      vectors++;
      if (in_ready !== er[c]) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: in_ready=%b, exp %b", c, in_ready, er[c]);
      end
      if (c == 1) snap = pc[0] - 32'h44;
      if (c >= 1 && c <= 4) begin
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== snap) begin
          miscompares++;
          $display("FAIL bp_hold[%0d]: out_valid=%b out_pc=%h, exp 1/%h", c, out_valid, out_pc, snap);
        end
      end
      if (er[c][0]) take(0);
    end
    tick();
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_counters();
    logic [6:0] vt = 7'b0111001;
    logic [6:0] spt = 7'b0110001;
    logic [6:0] ept = 7'b0111000;
    logic [3:0] tmt [7] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0101, 4'b0000, 4'b0000};
    logic [3:0] er [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic [63:0] bi, bt;
    bi = m_instrs;
    bt = m_threads;
    vectors++;
    if (retired_instrs !== bi || retired_threads !== bt) begin
      miscompares++;
      $display("FAIL cnt_base: instrs=%0d threads=%0d, exp %0d/%0d", retired_instrs, retired_threads, bi, bt);
    end
    for (int c = 0; c < 7; c++) begin
      tick();
      v[1] = vt[c]; sp[1] = spt[c]; ep[1] = ept[c]; tm[1] = tmt[c];
      #1;
      vectors++;
      if (in_ready !== er[c]) begin
        miscompares++;
        $display("FAIL cnt_ready[%0d]: in_ready=%b, exp %b", c, in_ready, er[c]);
      end
      if (c == 2) begin
        vectors++;
        if (retired_instrs !== bi || retired_threads !== bt) begin
          miscompares++;
          $display("FAIL cnt_noneop: instrs=%0d threads=%0d, exp %0d/%0d", retired_instrs, retired_threads, bi, bt);
        end
      end
      if (er[c][1] && v[1]) take(1);
    end
    tick();
    tick();
    #1;
    vectors++;
    if (retired_instrs !== bi + 64'd3 || retired_threads !== bt + 64'd6) begin
      miscompares++;
      $display("FAIL cnt_eop: instrs=%0d threads=%0d, exp %0d/%0d", retired_instrs, retired_threads, bi + 64'd3, bt + 64'd6);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [3:0] er [3] = '{4'b1000, 4'b1000, 4'b0000};
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      v[3] = 1'b1; sp[3] = (c == 0); ep[3] = 1'b0; tm[3] = 4'b1100;
      v[0] = (c == 2); sp[0] = 1'b1; ep[0] = 1'b1; tm[0] = 4'b0001;
      #1;
      vectors++;
      if (in_ready !== er[c]) begin
        miscompares++;
        $display("FAIL rst_pre[%0d]: in_ready=%b, exp %b", c, in_ready, er[c]);
      end
      if (er[c][3]) take(3);
    end
    tick();
    reset = 1'b1;
    sb.delete();
    m_instrs = '0;
    m_threads = '0;
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || retired_instrs !== 64'd0 || retired_threads !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b instrs=%0d threads=%0d, exp 0/0000/0/0",
               out_valid, in_ready, retired_instrs, retired_threads);
    end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    sp[3] = 1'b1; ep[3] = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_after0: in_ready=%b, exp 0001", in_ready);
    end
    take(0);
    tick();
    #1;
    vectors++;
    if (in_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL rst_after3: in_ready=%b, exp 1000", in_ready);
    end
    take(3);
    tick();
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_wrap();
    tick();
    force dut.retired_instrs = 64'hFFFF_FFFF_FFFF_FFFF;
    m_instrs = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    release dut.retired_instrs;
    #1;
    vectors++;
    if (retired_instrs !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_pre: instrs=%h, exp all ones", retired_instrs);
    end
    tick();
    v[0] = 1'b1; sp[0] = 1'b1; ep[0] = 1'b1; tm[0] = 4'b0011;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_ready: in_ready=%b, exp 0001", in_ready);
    end
    take(0);
    tick();
    idle_all();
    tick();
    tick();
    #1;
    vectors++;
    if (retired_instrs !== 64'd0 || retired_threads !== m_threads) begin
      miscompares++;
      $display("FAIL wrap: instrs=%0d threads=%0d, exp 0/%0d", retired_instrs, retired_threads, m_threads);
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      v[s] = 1'b0; pc[s] = 32'h100 * (s + 1); tm[s] = '0; sp[s] = 1'b0; ep[s] = 1'b0; bump[s] = 1'b0;
    end
    out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_counters();
    test_reset_mid_packet();
    test_wrap();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d packets never emerged, exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
